// File: rtl/decode_stage.sv
// decode_stage: register-file read and immediate decode into a single output register slice.
// Define DECODE_STAGE_WB_BYPASS_EN to forward same-edge write-back data into captured and held operands.
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int IMMW  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [$clog2(NREGS)-1:0]   in_rs,
    input  logic [$clog2(NREGS)-1:0]   in_rt,
    input  logic [$clog2(NREGS)-1:0]   in_rd,
    input  logic [IMMW-1:0]            in_imm,
    input  logic                       wb_en,
    input  logic [$clog2(NREGS)-1:0]   wb_rt,
    input  logic [$clog2(NREGS)-1:0]   wb_rd,
    input  logic                       wb_reg_dst,
    input  logic                       wb_mem_to_reg,
    input  logic [XLEN-1:0]            wb_alu_data,
    input  logic [XLEN-1:0]            wb_mem_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_rs_data,
    output logic [XLEN-1:0]            out_rt_data,
    output logic [XLEN-1:0]            out_sext_imm,
    output logic [XLEN-1:0]            out_sext_imm_sl2,
    output logic [XLEN-1:0]            out_zext_imm,
    output logic [XLEN-1:0]            out_jr_target,
    output logic [$clog2(NREGS)-1:0]   out_rs,
    output logic [$clog2(NREGS)-1:0]   out_rt,
    output logic [$clog2(NREGS)-1:0]   out_rd
);
    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] regs [NREGS];

    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            wb_hit;
    logic            accept;
    logic [XLEN-1:0] rs_rd_p0;
    logic [XLEN-1:0] rt_rd_p0;

    logic            vld_p1;
    logic [XLEN-1:0] rs_data_p1;
    logic [XLEN-1:0] rt_data_p1;
    logic [XLEN-1:0] sext_p1;
    logic [XLEN-1:0] sext_sl2_p1;
    logic [XLEN-1:0] zext_p1;
    logic [AW-1:0]   rs_p1;
    logic [AW-1:0]   rt_p1;
    logic [AW-1:0]   rd_p1;

    function automatic logic [XLEN-1:0] sext_imm(input logic [IMMW-1:0] imm);
        return {{(XLEN-IMMW){imm[IMMW-1]}}, imm};
    endfunction

    function automatic logic [XLEN-1:0] zext_imm(input logic [IMMW-1:0] imm);
        return {{(XLEN-IMMW){1'b0}}, imm};
    endfunction

    // Register 0 is never written, so it keeps its reset value of zero.
    assign wb_addr  = wb_reg_dst ? wb_rd : wb_rt;
    assign wb_data  = wb_mem_to_reg ? wb_mem_data : wb_alu_data;
    assign wb_hit   = wb_en && (wb_addr != '0);
    assign in_ready = !vld_p1 || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_hit) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // ---- p0: operand read (pre-write contents unless bypass is built in) ----
    always_comb begin
        rs_rd_p0 = regs[in_rs];
        rt_rd_p0 = regs[in_rt];
`ifdef DECODE_STAGE_WB_BYPASS_EN
        if (wb_hit && (wb_addr == in_rs)) rs_rd_p0 = wb_data;
        if (wb_hit && (wb_addr == in_rt)) rt_rd_p0 = wb_data;
`endif
    end

    // ---- p1: output bundle register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1      <= 1'b0;
            rs_data_p1  <= '0;
            rt_data_p1  <= '0;
            sext_p1     <= '0;
            sext_sl2_p1 <= '0;
            zext_p1     <= '0;
            rs_p1       <= '0;
            rt_p1       <= '0;
            rd_p1       <= '0;
        end else if (accept) begin
            vld_p1      <= 1'b1;
            rs_data_p1  <= rs_rd_p0;
            rt_data_p1  <= rt_rd_p0;
            sext_p1     <= sext_imm(in_imm);
            sext_sl2_p1 <= sext_imm(in_imm) << 2;
            zext_p1     <= zext_imm(in_imm);
            rs_p1       <= in_rs;
            rt_p1       <= in_rt;
            rd_p1       <= in_rd;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
`ifdef DECODE_STAGE_WB_BYPASS_EN
        end else if (vld_p1 && wb_hit) begin
            // A stalled bundle tracks later writes to its source registers.
            if (wb_addr == rs_p1) rs_data_p1 <= wb_data;
            if (wb_addr == rt_p1) rt_data_p1 <= wb_data;
`endif
        end
    end

    assign out_valid        = vld_p1;
    assign out_rs_data      = rs_data_p1;
    assign out_rt_data      = rt_data_p1;
    assign out_jr_target    = rs_data_p1;
    assign out_sext_imm     = sext_p1;
    assign out_sext_imm_sl2 = sext_sl2_p1;
    assign out_zext_imm     = zext_p1;
    assign out_rs           = rs_p1;
    assign out_rt           = rt_p1;
    assign out_rd           = rd_p1;

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and register width.
REQ-002 SHALL have parameter NREGS, default 32, register count (power of two, >=2); AW = log2(NREGS).
REQ-003 SHALL have parameter IMMW, default 16, instruction immediate field width (IMMW < XLEN-2).
REQ-004 SHALL have ports, one per line:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  instruction word valid
- in_ready  out  1  stage can accept an instruction
- in_rs, in_rt, in_rd  in  AW each  source/destination register fields
- in_imm  in  IMMW  immediate field
- wb_en  in  1  write-back enable
- wb_rt, wb_rd  in  AW each  write-back destination candidates
- wb_reg_dst  in  1  0 selects wb_rt, 1 selects wb_rd
- wb_mem_to_reg  in  1  0 selects wb_alu_data, 1 selects wb_mem_data
- wb_alu_data, wb_mem_data  in  XLEN each  write-back data candidates
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  downstream accepts bundle
- out_rs_data, out_rt_data  out  XLEN each  register operands
- out_sext_imm  out  XLEN  sign-extended immediate
- out_sext_imm_sl2  out  XLEN  out_sext_imm shifted left 2, upper bits dropped
- out_zext_imm  out  XLEN  zero-extended immediate
- out_jr_target  out  XLEN  copy of out_rs_data
- out_rs, out_rt, out_rd  out  AW each  registered copies of in_rs/in_rt/in_rd

Function
REQ-005 SHALL hold NREGS x XLEN registers; register 0 SHALL always read 0 and ignore writes.
REQ-006 SHALL write register (wb_reg_dst ? wb_rd : wb_rt) with (wb_mem_to_reg ? wb_mem_data : wb_alu_data) on a rising clk when wb_en=1.
REQ-007 SHALL drive in_ready = !out_valid | out_ready (combinational).
REQ-008 SHALL accept an instruction on a rising clk when in_valid & in_ready; all out_* SHALL present its decode on the next cycle (latency 1) with out_valid=1.
REQ-009 SHALL clear out_valid on a rising clk when out_ready=1 and no instruction is accepted.
REQ-010 SHALL hold all out_* unchanged while out_valid=1 and out_ready=0, except per REQ-014.
REQ-011 SHALL support back-to-back acceptance: out_valid & out_ready & in_valid loads the new bundle in the same edge with no bubble.
REQ-012 SHALL produce the immediate outputs from in_imm at accept: sign extension from bit IMMW-1, zero extension, and shift-left-2 of the sign-extended value.
REQ-013 SHALL never raise out_valid without an accepted instruction; in_valid while in_ready=0 SHALL be ignored.

Configuration
REQ-014 With macro DECODE_STAGE_WB_BYPASS_EN defined: at accept, an operand whose register equals a same-cycle write-back destination (nonzero, wb_en=1) SHALL capture the write-back data; while out_valid & !out_ready, a write-back to a held out_rs/out_rt (nonzero) SHALL update the held out_rs_data/out_rt_data (and out_jr_target) on that edge.
REQ-015 Without DECODE_STAGE_WB_BYPASS_EN: operands SHALL capture pre-write register contents at accept, and held operands SHALL never change.

Reset
REQ-016 While rst_n=0, and immediately on its assertion, out_valid SHALL be 0 and all other out_* and all registers SHALL be 0.
REQ-017 Reset asserted mid-operation SHALL discard the held bundle and any write-back on that edge; in_ready SHALL read 1 from the first cycle after rst_n rises.

Verification
REQ-018 Write r5=0x0000_1234 (wb_reg_dst=1, wb_rd=5, wb_mem_to_reg=0), then accept in_rs=5 -> next cycle out_valid=1, out_rs_data=out_jr_target=0x0000_1234.
REQ-019 in_imm=0x8004 -> out_sext_imm=0xFFFF_8004, out_sext_imm_sl2=0xFFFE_0010, out_zext_imm=0x0000_8004.
REQ-020 Write r0=0xDEAD_BEEF, then read in_rt=0 -> out_rt_data=0.
REQ-021 out_ready=0 for 3 cycles with bundle held -> in_ready=0, out_* stable; out_ready=1 with in_valid=1 -> new bundle next cycle, no bubble.
REQ-022 Bypass defined: accept in_rs=7 while writing r7=0x55 -> out_rs_data=0x55; then stall and write r7=0x66 -> held out_rs_data=0x66. Bypass undefined: same stimulus -> out_rs_data=old r7, remains so.
REQ-023 Assert rst_n=0 while out_valid=1 and out_ready=0 -> out_valid=0 immediately; r5 reads 0 after release.
